// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the sprite (OAM) DMA controller: state encoding,
// default register addresses and transfer length.
package dma_defs;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam int          OAM_XFER_LEN  = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        READ      = 3'd2,
        WAIT      = 3'd3,
        CAPTURE   = 3'd4,
        WRITE     = 3'd5,
        DONE      = 3'd6
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and memory-side bus signals around the OAM DMA controller.
// The slave modport is the controller's view; master is the surrounding system.
interface oam_dma_ctrl_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_write_en;
    logic        cpu_read_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [7:0]  mem_data_in;
    logic        cpu_halt;
    logic        dma_busy;

    modport slave (
        input  cpu_addr, cpu_data_out, cpu_write_en, cpu_read_en, mem_data_in,
        output mem_addr, mem_data_out, mem_write_en, mem_read_en, cpu_halt, dma_busy
    );

    modport master (
        output cpu_addr, cpu_data_out, cpu_write_en, cpu_read_en, mem_data_in,
        input  mem_addr, mem_data_out, mem_write_en, mem_read_en, cpu_halt, dma_busy
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: a CPU write to the DMA register halts the CPU and copies
// one 256-byte page to the OAM data port; otherwise the bus passes straight through.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = dma_defs::DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = dma_defs::OAM_DATA_ADDR,
    parameter int          HALT_SETTLE   = 2,
    parameter int          READ_LAT      = 2
) (
    input  logic           clk,
    input  logic           rst,
    oam_dma_ctrl_if.slave  bus
);

    import dma_defs::*;

    dma_state_t  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  data_reg_q, data_reg_d;
    logic        armed_q, armed_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic        cpu_halt_q, cpu_halt_d;
    logic        dma_busy_q, dma_busy_d;
    logic        trig;

    assign trig = bus.cpu_write_en && (bus.cpu_addr == DMA_REG_ADDR);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        page_d       = page_q;
        data_reg_d   = data_reg_q;
        armed_d      = armed_q;
        settle_cnt_d = settle_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        cpu_halt_d   = cpu_halt_q;
        dma_busy_d   = dma_busy_q;

        // Re-arm only once the strobe drops, so a held write cannot retrigger.
        if (!trig) armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (trig && armed_q) begin
                    page_d       = bus.cpu_data_out;
                    armed_d      = 1'b0;
                    cpu_halt_d   = 1'b1;
                    dma_busy_d   = 1'b1;
                    settle_cnt_d = 4'd0;
                    state_d      = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                if (settle_cnt_q == 4'(HALT_SETTLE - 1)) state_d = READ;
                else settle_cnt_d = settle_cnt_q + 4'd1;
            end
            READ: begin
                wait_cnt_d = 2'd0;
                state_d    = (READ_LAT == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == 2'(READ_LAT - 2)) state_d = CAPTURE;
                else wait_cnt_d = wait_cnt_q + 2'd1;
            end
            CAPTURE: begin
                data_reg_d = bus.mem_data_in;
                state_d    = WRITE;
            end
            WRITE: begin
                if (idx_q == 8'(OAM_XFER_LEN - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end
            default: begin
                // DONE, and any unused encoding, hand the bus back to the CPU.
                cpu_halt_d = 1'b0;
                dma_busy_d = 1'b0;
                idx_d      = 8'd0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 8'd0;
            page_q       <= 8'd0;
            data_reg_q   <= 8'd0;
            armed_q      <= 1'b1;
            settle_cnt_q <= 4'd0;
            wait_cnt_q   <= 2'd0;
            cpu_halt_q   <= 1'b0;
            dma_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            page_q       <= page_d;
            data_reg_q   <= data_reg_d;
            armed_q      <= armed_d;
            settle_cnt_q <= settle_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_halt_q   <= cpu_halt_d;
            dma_busy_q   <= dma_busy_d;
        end
    end

    // Bus mux: CPU owns the bus while idle or settling; DMA owns it otherwise.
    always_comb begin
        bus.mem_addr     = {page_q, idx_q};
        bus.mem_data_out = 8'h00;
        bus.mem_write_en = 1'b0;
        bus.mem_read_en  = 1'b0;
        case (state_q)
            IDLE, HALT_WAIT: begin
                bus.mem_addr     = bus.cpu_addr;
                bus.mem_data_out = bus.cpu_data_out;
                bus.mem_write_en = bus.cpu_write_en;
                bus.mem_read_en  = bus.cpu_read_en;
            end
            READ: begin
                bus.mem_read_en = 1'b1;
            end
            WRITE: begin
                bus.mem_addr     = OAM_DATA_ADDR;
                bus.mem_data_out = data_reg_q;
                bus.mem_write_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cpu_halt = cpu_halt_q;
    assign bus.dma_busy = dma_busy_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: default build (dut 0) and a READ_LAT=1 build (dut 1),
// with per-build read/write scoreboards filled at trigger time and drained by a bus monitor.
module tb_oam_dma_ctrl;

    localparam int HS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oam_dma_ctrl_if bus0();
    oam_dma_ctrl_if bus1();

    oam_dma_ctrl #(.HALT_SETTLE(HS), .READ_LAT(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    oam_dma_ctrl #(.HALT_SETTLE(HS), .READ_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_rd [2][$];
    logic [7:0]  exp_wr [2][$];
    int  first_rd [2];
    int  last_wr  [2];
    int  n_wr     [2];
    bit  xfer_start [2];
    bit  mute [2];
    int  trig_cyc;
    int  lat [2] = '{2, 1};

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
    endfunction

    // Memory models: data appears READ_LAT cycles after the read pulse.
    logic [15:0] rd_a0;
    logic        rd_v0;
    always @(posedge clk) begin
        rd_v0 <= bus0.mem_read_en;
        rd_a0 <= bus0.mem_addr;
        if (rd_v0) bus0.mem_data_in <= mem_fn(rd_a0);
        else       bus0.mem_data_in <= 8'hxx;
    end
    always @(posedge clk) begin
        if (bus1.mem_read_en) bus1.mem_data_in <= mem_fn(bus1.mem_addr);
        else                  bus1.mem_data_in <= 8'hxx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_step(input int k, input logic [15:0] a, input logic [7:0] d,
                            input logic we, input logic re, input logic halt);
        logic [15:0] ea;
        logic [7:0]  ed;
        if (!mute[k] && halt) begin
            if (re) begin
                check("rd_we_excl", 32'(we), 32'd0);
                check("rd_expected", 32'(exp_rd[k].size() != 0), 32'd1);
                if (exp_rd[k].size() != 0) begin
                    if (xfer_start[k]) begin first_rd[k] = cyc; xfer_start[k] = 1'b0; end
                    ea = exp_rd[k].pop_front();
                    check("rd_addr", 32'(a), 32'(ea));
                end
            end
            if (we && a != 16'h4014) begin
                check("wr_expected", 32'(exp_wr[k].size() != 0), 32'd1);
                if (exp_wr[k].size() != 0) begin
                    ed = exp_wr[k].pop_front();
                    check("wr_addr", 32'(a), 32'h2004);
                    check("wr_data", 32'(d), 32'(ed));
                    if (n_wr[k] > 0) check("byte_cycles", 32'(cyc - last_wr[k]), 32'(lat[k] + 2));
                    n_wr[k]++;
                    last_wr[k] = cyc;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, bus0.mem_addr, bus0.mem_data_out, bus0.mem_write_en, bus0.mem_read_en, bus0.cpu_halt);
        mon_step(1, bus1.mem_addr, bus1.mem_data_out, bus1.mem_write_en, bus1.mem_read_en, bus1.cpu_halt);
    end

    task automatic drive(input int k, input logic [15:0] a, input logic [7:0] d, input logic we);
        if (k == 0) begin
            bus0.cpu_addr = a; bus0.cpu_data_out = d; bus0.cpu_write_en = we;
        end else begin
            bus1.cpu_addr = a; bus1.cpu_data_out = d; bus1.cpu_write_en = we;
        end
    endtask

    function automatic logic get_halt(input int k);
        return (k == 0) ? bus0.cpu_halt : bus1.cpu_halt;
    endfunction

    function automatic logic get_busy(input int k);
        return (k == 0) ? bus0.dma_busy : bus1.dma_busy;
    endfunction

    task automatic push_xfer(input int k, input logic [7:0] page);
        for (int i = 0; i < 256; i++) begin
            exp_rd[k].push_back({page, 8'(i)});
            exp_wr[k].push_back(mem_fn({page, 8'(i)}));
        end
        n_wr[k] = 0;
        xfer_start[k] = 1'b1;
    endtask

    // Trigger with the strobe held for 'hold' cycles; strobe left high when keep=1.
    task automatic trigger(input int k, input logic [7:0] page, input int hold, input bit keep);
        push_xfer(k, page);
        @(posedge clk); #1;
        drive(k, 16'h4014, page, 1'b1);
        trig_cyc = cyc;
        repeat (hold) begin @(posedge clk); #1; end
        if (!keep) drive(k, 16'h0000, 8'h00, 1'b0);
    endtask

    task automatic wait_done(input int k, output int fall);
        int n;
        n = 0;
        fall = -1;
        while (n < 2000 && fall < 0) begin
            @(negedge clk);
            n++;
            if (!get_busy(k) && exp_wr[k].size() == 0) fall = cyc;
        end
        check("done_in_budget", 32'(fall >= 0), 32'd1);
    endtask

    task automatic finish_xfer(input int k);
        int fall;
        wait_done(k, fall);
        check("first_rd_lat", 32'(first_rd[k] - trig_cyc), 32'(HS + 1));
        check("xfer_cycles", 32'(last_wr[k] - first_rd[k] + 1), 32'(256 * (lat[k] + 2)));
        check("n_writes", 32'(n_wr[k]), 32'd256);
        check("halt_fall_cyc", 32'(fall), 32'(last_wr[k] + 2));
        check("halt_low", 32'(get_halt(k)), 32'd0);
        check("rd_q_empty", 32'(exp_rd[k].size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        drive(0, 16'h0000, 8'h00, 1'b0);
        drive(1, 16'h0000, 8'h00, 1'b0);
        bus0.cpu_read_en = 1'b0;
        bus1.cpu_read_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_halt0", 32'(bus0.cpu_halt), 32'd0);
        check("rst_busy0", 32'(bus0.dma_busy), 32'd0);
        check("rst_halt1", 32'(bus1.cpu_halt), 32'd0);
        check("rst_busy1", 32'(bus1.dma_busy), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Pass-through write and read
        @(posedge clk); #1 drive(0, 16'h0300, 8'h5A, 1'b1);
        @(negedge clk);
        check("pt_addr", 32'(bus0.mem_addr), 32'h0300);
        check("pt_data", 32'(bus0.mem_data_out), 32'h5A);
        check("pt_we", 32'(bus0.mem_write_en), 32'd1);
        check("pt_halt", 32'(bus0.cpu_halt), 32'd0);
        @(posedge clk); #1 drive(0, 16'h1234, 8'h00, 1'b0); bus0.cpu_read_en = 1'b1;
        @(negedge clk);
        check("pt_rd_addr", 32'(bus0.mem_addr), 32'h1234);
        check("pt_re", 32'(bus0.mem_read_en), 32'd1);
        check("pt_rd_we", 32'(bus0.mem_write_en), 32'd0);
        @(posedge clk); #1 bus0.cpu_read_en = 1'b0;

        // Full DMA from page $02
        trigger(0, 8'h02, 1, 1'b0);
        @(negedge clk);
        check("halt_next", 32'(bus0.cpu_halt), 32'd1);
        check("busy_next", 32'(bus0.dma_busy), 32'd1);
        finish_xfer(0);

        // Strobe held 10 cycles: exactly one DMA
        trigger(0, 8'h02, 10, 1'b0);
        finish_xfer(0);
        repeat (10) @(negedge clk);
        check("held10_no_retrig", 32'(bus0.dma_busy), 32'd0);

        // Strobe held through the whole DMA: no retrigger until it drops and returns
        trigger(0, 8'h03, 1, 1'b1);
        finish_xfer(0);
        repeat (6) @(negedge clk);
        check("held_no_retrig", 32'(bus0.dma_busy), 32'd0);
        @(posedge clk); #1 drive(0, 16'h0000, 8'h00, 1'b0);
        trigger(0, 8'h04, 1, 1'b0);
        finish_xfer(0);

        // Page $FF must stay within $FF00-$FFFF
        trigger(0, 8'hFF, 1, 1'b0);
        finish_xfer(0);

        // Reset at byte 100
        trigger(0, 8'h05, 1, 1'b0);
        n = 0;
        while (n < 1000 && n_wr[0] < 100) begin @(negedge clk); n++; end
        check("reach_byte100", 32'(n_wr[0]), 32'd100);
        @(posedge clk); #1;
        mute[0] = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_halt", 32'(bus0.cpu_halt), 32'd0);
        check("rst_mid_busy", 32'(bus0.dma_busy), 32'd0);
        check("rst_mid_we", 32'(bus0.mem_write_en), 32'd0);
        exp_rd[0].delete();
        exp_wr[0].delete();
        mute[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_idle", 32'(bus0.dma_busy), 32'd0);
        trigger(0, 8'h05, 1, 1'b0);
        finish_xfer(0);

        // READ_LAT=1 build
        trigger(1, 8'h02, 1, 1'b0);
        @(negedge clk);
        check("lat1_halt_next", 32'(bus1.cpu_halt), 32'd1);
        finish_xfer(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
